// File: rtl/nrisc_dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nrisc_dmem_ctrl_pkg
// Shared constants for the NRISC-Aurora data-memory controller:
//   - access-control field encodings (size/lane in core_ctrl[1:0], zero-extend
//     flag at bit DMEM_ZEXT)
//   - controller state encodings
//   - default parameter values (data width, local RAM depth, ack timeout)
// -----------------------------------------------------------------------------
package nrisc_dmem_ctrl_pkg;

   localparam int DMEM_TAM_DEF        = 16;
   localparam int DMEM_N_DDATA_DEF    = 8;
   localparam int DMEM_WB_TIMEOUT_DEF = 255;

   // core_ctrl[1:0]: 2'b11 is reserved and behaves as a full-word access
   localparam logic [1:0] DMEM_SZ_WORD = 2'b00;
   localparam logic [1:0] DMEM_SZ_B0   = 2'b01;
   localparam logic [1:0] DMEM_SZ_B1   = 2'b10;
   localparam int         DMEM_ZEXT    = 2;

   typedef enum logic [1:0] {
      DMEM_IDLE  = 2'd0,
      DMEM_LOCAL = 2'd1,
      DMEM_WB    = 2'd2,
      DMEM_RESP  = 2'd3
   } dmem_state_e;

endpackage

// File: rtl/nrisc_dmem_ram.sv
// -----------------------------------------------------------------------------
// nrisc_dmem_ram
// Single-port synchronous RAM with per-byte write enables and registered read
// data. A read returns the word as it was before any write in the same cycle.
// Ports:
//   clk    in   clock
//   en     in   access enable (read and/or write this cycle)
//   we     in   write enable, qualified per byte by be
//   be     in   TAM/8 byte enables
//   addr   in   N_DDATA word index
//   wdata  in   TAM write data (lane i taken from bits [8i+7:8i])
//   rdata  out  TAM registered read data, updated on enabled cycles only
// -----------------------------------------------------------------------------
module nrisc_dmem_ram
   import nrisc_dmem_ctrl_pkg::*;
#(
   parameter int TAM     = DMEM_TAM_DEF,
   parameter int N_DDATA = DMEM_N_DDATA_DEF
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [TAM/8-1:0]     be,
   input  logic [N_DDATA-1:0]   addr,
   input  logic [TAM-1:0]       wdata,
   output logic [TAM-1:0]       rdata
);

   logic [TAM-1:0] mem [2**N_DDATA];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < TAM/8; i++) begin
            if (we && be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/nrisc_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// nrisc_dmem_ctrl
// Data-memory controller between the core load/store stage and the data space.
// Lower half of the address space (core_addr[TAM-1]=0) is a local byte-enable
// RAM that aliases on the unused address bits; the upper half is reached
// through a Wishbone classic master. Byte/word access with sign or zero
// extension is selected by core_ctrl.
// Optional feature: define NRISC_DMEM_WB_TIMEOUT_EN to abort a Wishbone cycle
// with core_err=1 after WB_TIMEOUT cycles without ack/err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   core_req/we/addr/wdata   request (sampled in IDLE only, held until ready)
//   core_ctrl                [1:0] size/lane, [2] zero-extend
//   core_rdata               load result, registered, valid with core_ready
//   core_ready               one-cycle completion pulse
//   core_err                 bus error/timeout, qualified by core_ready
//   wb_cyc_o/stb_o/we_o      Wishbone master strobes
//   wb_adr_o                 word address core_addr[TAM-2:0]
//   wb_dat_o, wb_sel_o       write data and byte selects
//   wb_dat_i, wb_ack_i, wb_err_i   slave read data and termination
// -----------------------------------------------------------------------------
module nrisc_dmem_ctrl
   import nrisc_dmem_ctrl_pkg::*;
#(
   parameter int TAM        = DMEM_TAM_DEF,
   parameter int N_DDATA    = DMEM_N_DDATA_DEF,
   parameter int WB_TIMEOUT = DMEM_WB_TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               core_req,
   input  logic               core_we,
   input  logic [TAM-1:0]     core_addr,
   input  logic [TAM-1:0]     core_wdata,
   input  logic [2:0]         core_ctrl,
   output logic [TAM-1:0]     core_rdata,
   output logic               core_ready,
   output logic               core_err,
   output logic               wb_cyc_o,
   output logic               wb_stb_o,
   output logic               wb_we_o,
   output logic [TAM-2:0]     wb_adr_o,
   output logic [TAM-1:0]     wb_dat_o,
   output logic [TAM/8-1:0]   wb_sel_o,
   input  logic [TAM-1:0]     wb_dat_i,
   input  logic               wb_ack_i,
   input  logic               wb_err_i
);

   localparam int NB = TAM / 8;

   if ((TAM % 8) != 0 || TAM < 16 || N_DDATA < 1 || N_DDATA > TAM - 1 || WB_TIMEOUT < 1)
   begin : g_param_check
      $error("nrisc_dmem_ctrl: illegal TAM/N_DDATA/WB_TIMEOUT combination");
   end

   // Right-align the selected byte and extend it; full-word accesses pass through.
   function automatic logic [TAM-1:0] load_ext(input logic [TAM-1:0] data,
                                               input logic [2:0]     ctrl);
      logic signed [7:0] b;
      logic [TAM-1:0]    res;
      b = (ctrl[1:0] == DMEM_SZ_B1) ? data[15:8] : data[7:0];
      case (ctrl[1:0])
         DMEM_SZ_B0, DMEM_SZ_B1: res = ctrl[DMEM_ZEXT] ? {{(TAM-8){1'b0}}, b} : TAM'(b);
         default:                res = data;
      endcase
      return res;
   endfunction

   function automatic logic [NB-1:0] sel_of(input logic [1:0] sz);
      logic [NB-1:0] s;
      case (sz)
         DMEM_SZ_WORD: s = '1;
         DMEM_SZ_B0:   s = NB'(1);
         DMEM_SZ_B1:   s = NB'(2);
         default:      s = '1;
      endcase
      return s;
   endfunction

   // Byte stores replicate the byte on every lane; the selects pick the lane.
   function automatic logic [TAM-1:0] store_data(input logic [TAM-1:0] wdata,
                                                 input logic [1:0]     sz);
      logic [TAM-1:0] d;
      if (sz == DMEM_SZ_B0 || sz == DMEM_SZ_B1) begin
         d = {NB{wdata[7:0]}};
      end else begin
         d = wdata;
      end
      return d;
   endfunction

   dmem_state_e     state;
   logic            we_p0;
   logic [2:0]      ctrl_p0;
   logic [TAM-1:0]  wb_rdata_p1;
   logic            wb_err_p1;

   logic            ram_en;
   logic [NB-1:0]   ram_be;
   logic [TAM-1:0]  ram_rdata;

`ifdef NRISC_DMEM_WB_TIMEOUT_EN
   localparam int CNT_W = $clog2(WB_TIMEOUT + 1);
   logic [CNT_W-1:0] tmo_cnt_p1;
`endif

   // ---- stage p0: request acceptance; the RAM is accessed on the accept edge
   assign ram_en = (state == DMEM_IDLE) && core_req && !rst && !core_addr[TAM-1];
   assign ram_be = core_we ? sel_of(core_ctrl[1:0]) : '0;

   nrisc_dmem_ram #(
      .TAM     (TAM),
      .N_DDATA (N_DDATA)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (core_we),
      .be    (ram_be),
      .addr  (core_addr[N_DDATA-1:0]),
      .wdata (store_data(core_wdata, core_ctrl[1:0])),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DMEM_IDLE;
         core_ready <= 1'b0;
         core_err   <= 1'b0;
         core_rdata <= '0;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         wb_sel_o   <= '0;
      end else begin
         core_ready <= 1'b0;
         case (state)
            DMEM_IDLE: begin
               if (core_req) begin
                  we_p0   <= core_we;
                  ctrl_p0 <= core_ctrl;
                  if (core_addr[TAM-1]) begin
                     state    <= DMEM_WB;
                     wb_cyc_o <= 1'b1;
                     wb_stb_o <= 1'b1;
                     wb_we_o  <= core_we;
                     wb_adr_o <= core_addr[TAM-2:0];
                     wb_dat_o <= store_data(core_wdata, core_ctrl[1:0]);
                     wb_sel_o <= sel_of(core_ctrl[1:0]);
`ifdef NRISC_DMEM_WB_TIMEOUT_EN
                     tmo_cnt_p1 <= '0;
`endif
                  end else begin
                     state <= DMEM_LOCAL;
                  end
               end
            end

            // ---- stage p1: local RAM read data available, respond
            DMEM_LOCAL: begin
               core_ready <= 1'b1;
               core_err   <= 1'b0;
               core_rdata <= we_p0 ? '0 : load_ext(ram_rdata, ctrl_p0);
               state      <= DMEM_IDLE;
            end

            // ---- stage p1: Wishbone cycle open until the slave terminates
            DMEM_WB: begin
               if (wb_ack_i || wb_err_i) begin
                  wb_rdata_p1 <= wb_dat_i;
                  wb_err_p1   <= wb_err_i;
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  wb_we_o     <= 1'b0;
                  state       <= DMEM_RESP;
               end
`ifdef NRISC_DMEM_WB_TIMEOUT_EN
               // A zeroed capture register makes the response data 0 for any ctrl.
               else if (tmo_cnt_p1 == CNT_W'(WB_TIMEOUT)) begin
                  wb_rdata_p1 <= '0;
                  wb_err_p1   <= 1'b1;
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  wb_we_o     <= 1'b0;
                  state       <= DMEM_RESP;
               end else begin
                  tmo_cnt_p1 <= tmo_cnt_p1 + CNT_W'(1);
               end
`endif
            end

            // ---- stage p2: Wishbone response to the core
            DMEM_RESP: begin
               core_ready <= 1'b1;
               core_err   <= wb_err_p1;
               core_rdata <= we_p0 ? '0 : load_ext(wb_rdata_p1, ctrl_p0);
               state      <= DMEM_IDLE;
            end

            default: state <= DMEM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nrisc_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nrisc_dmem_ctrl
// Self-checking bench for nrisc_dmem_ctrl (TAM=16, N_DDATA=4, WB_TIMEOUT=8).
// A word-array model of the local RAM and an associative-array Wishbone slave
// provide all expected values. Define NRISC_DMEM_WB_TIMEOUT_EN to include the
// timeout scenario.
// -----------------------------------------------------------------------------
module tb_nrisc_dmem_ctrl;

   localparam int CYC_BUDGET = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we;
   logic [15:0] core_addr, core_wdata;
   logic [2:0]  core_ctrl;
   logic [15:0] core_rdata;
   logic        core_ready, core_err;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [14:0] wb_adr_o;
   logic [15:0] wb_dat_o;
   logic [1:0]  wb_sel_o;
   logic [15:0] wb_dat_i;
   logic        wb_ack_i, wb_err_i;

   int n_vec = 0;
   int n_bad = 0;

   logic [15:0] ref_mem [16];
   logic [15:0] wb_mem [int];

   logic        bus_seen;
   logic [14:0] obs_adr;
   logic [1:0]  obs_sel;
   logic [15:0] obs_dat;
   logic        obs_we;

   nrisc_dmem_ctrl #(
      .TAM        (16),
      .N_DDATA    (4),
      .WB_TIMEOUT (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_ctrl  (core_ctrl),
      .core_rdata (core_rdata),
      .core_ready (core_ready),
      .core_err   (core_err),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_sel_o   (wb_sel_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Reference behaviour of a load: pick the byte, then extend it arithmetically.
   function automatic logic [15:0] model_load(input logic [15:0] w, input logic [2:0] ctrl);
      int b;
      if (ctrl[1:0] == 2'b01)      b = int'(w) % 256;
      else if (ctrl[1:0] == 2'b10) b = int'(w) / 256;
      else                         return w;
      if (!ctrl[2] && b >= 128) b = b - 256;
      return 16'(b);
   endfunction

   function automatic logic [15:0] model_store(input logic [15:0] old, input logic [15:0] wdata,
                                               input logic [2:0] ctrl);
      int o, d;
      o = int'(old);
      d = int'(wdata) % 256;
      if (ctrl[1:0] == 2'b01)      return 16'(o - o % 256 + d);
      else if (ctrl[1:0] == 2'b10) return 16'(d * 256 + o % 256);
      else                         return wdata;
   endfunction

   function automatic logic [1:0] model_sel(input logic [2:0] ctrl);
      if (ctrl[1:0] == 2'b01) return 2'b01;
      if (ctrl[1:0] == 2'b10) return 2'b10;
      return 2'b11;
   endfunction

   // Drives one request and plays the Wishbone slave. mode: 0 ack, 1 err, 2 both.
   // wait_n < 0: slave never terminates. lat = edges from accept to core_ready.
   task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [2:0] ctrl, input int wait_n, input int mode,
                            output logic [15:0] rdata, output logic err, output int lat);
      int seen;
      int a;
      seen = 0;
      lat = -1;
      rdata = 'x;
      err = 'x;
      bus_seen = 1'b0;
      core_req = 1'b1;
      core_we = we;
      core_addr = addr;
      core_wdata = wdata;
      core_ctrl = ctrl;
      for (int c = 0; c < CYC_BUDGET; c++) begin
         @(posedge clk);
         #1;
         if (core_ready) begin
            lat = c;
            rdata = core_rdata;
            err = core_err;
            break;
         end
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         wb_dat_i = 16'($urandom);
         if (wb_cyc_o && wb_stb_o) begin
            if (!bus_seen) begin
               bus_seen = 1'b1;
               obs_adr = wb_adr_o;
               obs_sel = wb_sel_o;
               obs_dat = wb_dat_o;
               obs_we = wb_we_o;
            end
            seen++;
            if (wait_n >= 0 && seen > wait_n) begin
               a = int'(wb_adr_o);
               if (!wb_mem.exists(a)) wb_mem[a] = 16'($urandom);
               wb_ack_i = (mode != 1);
               wb_err_i = (mode != 0);
               if (mode == 0 && wb_we_o) begin
                  if (wb_sel_o[0]) wb_mem[a][7:0] = wb_dat_o[7:0];
                  if (wb_sel_o[1]) wb_mem[a][15:8] = wb_dat_o[15:8];
               end else if (!wb_we_o) begin
                  wb_dat_i = wb_mem[a];
               end
            end
         end
      end
      core_req = 1'b0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_ctrl = '0;
      wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (core_ready !== 1'b0 || core_err !== 1'b0 || core_rdata !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_core: ready=%b err=%b rdata=%h required 0/0/0000", core_ready, core_err, core_rdata);
      end
      n_vec++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000 || wb_adr_o !== 15'h0 || wb_dat_o !== 16'h0 || wb_sel_o !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_wb: cyc/stb/we=%b adr=%h dat=%h sel=%b required all zero",
                  {wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o, wb_dat_o, wb_sel_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_local_word();
      logic [15:0] rd; logic er; int lat;
      do_access(1'b1, 16'h0005, 16'hBEEF, 3'b000, 0, 0, rd, er, lat);
      ref_mem[5] = 16'hBEEF;
      n_vec++;
      if (lat !== 1 || er !== 1'b0 || rd !== 16'h0) begin
         n_bad++;
         $display("FAIL local_word_store: lat=%0d err=%b rdata=%h required 1/0/0000", lat, er, rd);
      end
      do_access(1'b0, 16'h0005, 16'h0000, 3'b000, 0, 0, rd, er, lat);
      n_vec++;
      if (lat !== 1 || er !== 1'b0 || rd !== 16'hBEEF) begin
         n_bad++;
         $display("FAIL local_word_load: lat=%0d err=%b rdata=%h required 1/0/beef", lat, er, rd);
      end
   endtask

   task automatic test_local_byte();
      logic [15:0] rd; logic er; int lat;
      logic [2:0]  ctrls [4];
      logic [15:0] exps  [4];
      ctrls = '{3'b001, 3'b101, 3'b010, 3'b110};
      exps  = '{16'hFFFF, 16'h00FF, 16'hFF80, 16'h0080};
      do_access(1'b1, 16'h0002, 16'h80FF, 3'b000, 0, 0, rd, er, lat);
      ref_mem[2] = 16'h80FF;
      for (int i = 0; i < 4; i++) begin
         do_access(1'b0, 16'h0002, 16'h0000, ctrls[i], 0, 0, rd, er, lat);
         n_vec++;
         if (lat !== 1 || rd !== exps[i]) begin
            n_bad++;
            $display("FAIL local_byte_load ctrl=%b: lat=%0d rdata=%h required 1/%h", ctrls[i], lat, rd, exps[i]);
         end
      end
   endtask

   task automatic test_byte_store();
      logic [15:0] rd; logic er; int lat;
      do_access(1'b1, 16'h0007, 16'hAAAA, 3'b000, 0, 0, rd, er, lat);
      do_access(1'b1, 16'h0007, 16'h3412, 3'b010, 0, 0, rd, er, lat);
      do_access(1'b0, 16'h0007, 16'h0000, 3'b000, 0, 0, rd, er, lat);
      n_vec++;
      if (rd !== 16'h12AA) begin
         n_bad++;
         $display("FAIL byte_store_lane1: rdata=%h required 12aa", rd);
      end
      do_access(1'b1, 16'h0007, 16'hC356, 3'b101, 0, 0, rd, er, lat);
      do_access(1'b0, 16'h0007, 16'h0000, 3'b011, 0, 0, rd, er, lat);
      n_vec++;
      if (rd !== 16'h1256) begin
         n_bad++;
         $display("FAIL byte_store_lane0: rdata=%h required 1256", rd);
      end
      ref_mem[7] = 16'h1256;
   endtask

   task automatic test_alias();
      logic [15:0] rd; logic er; int lat;
      do_access(1'b1, 16'h7FF9, 16'h1357, 3'b000, 0, 0, rd, er, lat);
      ref_mem[9] = 16'h1357;
      do_access(1'b0, 16'h0009, 16'h0000, 3'b000, 0, 0, rd, er, lat);
      n_vec++;
      if (rd !== 16'h1357 || lat !== 1) begin
         n_bad++;
         $display("FAIL alias: lat=%0d rdata=%h required 1/1357", lat, rd);
      end
   endtask

   task automatic test_random_local();
      logic [15:0] rd, wd, ad, exp; logic er; int lat; int idx; logic we; logic [2:0] ct;
      for (int i = 0; i < 16; i++) begin
         wd = 16'($urandom);
         ad = {1'b0, 11'($urandom), 4'(i)};
         do_access(1'b1, ad, wd, 3'b000, 0, 0, rd, er, lat);
         ref_mem[i] = wd;
      end
      for (int n = 0; n < 60; n++) begin
         idx = $urandom_range(0, 15);
         ad = {1'b0, 11'($urandom), 4'(idx)};
         we = 1'($urandom);
         ct = 3'($urandom);
         wd = 16'($urandom);
         exp = we ? 16'h0 : model_load(ref_mem[idx], ct);
         do_access(we, ad, wd, ct, 0, 0, rd, er, lat);
         if (we) ref_mem[idx] = model_store(ref_mem[idx], wd, ct);
         n_vec++;
         if (lat !== 1 || er !== 1'b0 || rd !== exp) begin
            n_bad++;
            $display("FAIL random_local #%0d we=%b addr=%h ctrl=%b: lat=%0d err=%b rdata=%h required 1/0/%h",
                     n, we, ad, ct, lat, er, rd, exp);
         end
      end
   endtask

   task automatic test_wb_load();
      logic [15:0] rd; logic er; int lat;
      do_access(1'b0, 16'h8003, 16'h0000, 3'b000, 3, 0, rd, er, lat);
      n_vec++;
      if (obs_adr !== 15'h0003 || obs_sel !== 2'b11 || obs_we !== 1'b0) begin
         n_bad++;
         $display("FAIL wb_load_bus: adr=%h sel=%b we=%b required 0003/11/0", obs_adr, obs_sel, obs_we);
      end
      n_vec++;
      if (lat !== 5 || er !== 1'b0 || rd !== wb_mem[3]) begin
         n_bad++;
         $display("FAIL wb_load_resp: lat=%0d err=%b rdata=%h required 5/0/%h", lat, er, rd, wb_mem[3]);
      end
      do_access(1'b0, 16'h8004, 16'h0000, 3'b000, 0, 0, rd, er, lat);
      n_vec++;
      if (lat !== 2 || rd !== wb_mem[4]) begin
         n_bad++;
         $display("FAIL wb_zero_wait: lat=%0d rdata=%h required 2/%h", lat, rd, wb_mem[4]);
      end
      wb_mem[3] = 16'h9C41;
      do_access(1'b0, 16'h8003, 16'h0000, 3'b010, 1, 0, rd, er, lat);
      n_vec++;
      if (obs_sel !== 2'b10 || lat !== 3 || rd !== 16'hFF9C) begin
         n_bad++;
         $display("FAIL wb_byte_load: sel=%b lat=%0d rdata=%h required 10/3/ff9c", obs_sel, lat, rd);
      end
   endtask

   task automatic test_wb_store();
      logic [15:0] rd; logic er; int lat;
      wb_mem[16] = 16'hAAAA;
      do_access(1'b1, 16'h8010, 16'h775A, 3'b001, 2, 0, rd, er, lat);
      n_vec++;
      if (obs_we !== 1'b1 || obs_sel !== 2'b01 || obs_dat[7:0] !== 8'h5A || obs_adr !== 15'h0010) begin
         n_bad++;
         $display("FAIL wb_store_bus: we=%b sel=%b dat=%h adr=%h required 1/01/xx5a/0010", obs_we, obs_sel, obs_dat, obs_adr);
      end
      n_vec++;
      if (lat !== 4 || er !== 1'b0 || rd !== 16'h0 || wb_mem[16] !== 16'hAA5A) begin
         n_bad++;
         $display("FAIL wb_store_resp: lat=%0d err=%b rdata=%h mem=%h required 4/0/0000/aa5a", lat, er, rd, wb_mem[16]);
      end
   endtask

   task automatic test_wb_error();
      logic [15:0] rd; logic er; int lat;
      do_access(1'b1, 16'h8011, 16'h1234, 3'b000, 2, 1, rd, er, lat);
      n_vec++;
      if (lat !== 4 || er !== 1'b1 || rd !== 16'h0) begin
         n_bad++;
         $display("FAIL wb_err_store: lat=%0d err=%b rdata=%h required 4/1/0000", lat, er, rd);
      end
      do_access(1'b0, 16'h8012, 16'h0000, 3'b000, 0, 2, rd, er, lat);
      n_vec++;
      if (lat !== 2 || er !== 1'b1) begin
         n_bad++;
         $display("FAIL wb_ack_and_err: lat=%0d err=%b required 2/1", lat, er);
      end
      do_access(1'b0, 16'h0005, 16'h0000, 3'b000, 0, 0, rd, er, lat);
      n_vec++;
      if (er !== 1'b0 || rd !== ref_mem[5]) begin
         n_bad++;
         $display("FAIL err_clears_on_local: err=%b rdata=%h required 0/%h", er, rd, ref_mem[5]);
      end
   endtask

   task automatic test_random_wb();
      logic [15:0] rd, wd, ad, exp, msk; logic er; int lat; int w, mode; logic we; logic [2:0] ct;
      logic [14:0] a15;
      for (int n = 0; n < 30; n++) begin
         a15 = 15'($urandom_range(0, 15)) | (15'($urandom_range(0, 3)) << 12);
         ad = {1'b1, a15};
         we = 1'($urandom);
         ct = 3'($urandom);
         wd = 16'($urandom);
         w = $urandom_range(0, 4);
         mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
         do_access(we, ad, wd, ct, w, mode, rd, er, lat);
         exp = (we || mode != 0) ? 16'h0 : model_load(wb_mem[int'(a15)], ct);
         msk = (mode != 0 && !we) ? 16'h0000 : 16'hFFFF;
         n_vec++;
         if (lat !== w + 2 || er !== (mode != 0) || (rd & msk) !== exp || obs_adr !== a15
             || obs_sel !== model_sel(ct) || obs_we !== we) begin
            n_bad++;
            $display("FAIL random_wb #%0d we=%b adr=%h ctrl=%b: lat=%0d err=%b rdata=%h adr=%h sel=%b required %0d/%0d/%h/%h/%b",
                     n, we, ad, ct, lat, er, rd, obs_adr, obs_sel, w + 2, (mode != 0), exp, a15, model_sel(ct));
         end
         if (we) begin
            msk = (ct[1:0] == 2'b01) ? 16'h00FF : (ct[1:0] == 2'b10) ? 16'hFF00 : 16'hFFFF;
            exp = (ct[1:0] == 2'b01 || ct[1:0] == 2'b10) ? {wd[7:0], wd[7:0]} : wd;
            n_vec++;
            if ((obs_dat & msk) !== (exp & msk)) begin
               n_bad++;
               $display("FAIL random_wb_dat #%0d: dat=%h required %h under mask %h", n, obs_dat, exp, msk);
            end
         end
      end
   endtask

   task automatic test_wb_reset();
      logic [15:0] rd; logic er; int lat;
      int ready_seen;
      core_req = 1'b1; core_we = 1'b0; core_addr = 16'h8020; core_ctrl = 3'b000; core_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
         n_bad++;
         $display("FAIL wb_reset_open: cyc=%b stb=%b required 1/1", wb_cyc_o, wb_stb_o);
      end
      rst = 1'b1;
      core_req = 1'b0;
      @(posedge clk);
      #1;
      n_vec++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
         n_bad++;
         $display("FAIL wb_reset_drop: cyc=%b stb=%b required 0/0", wb_cyc_o, wb_stb_o);
      end
      rst = 1'b0;
      wb_ack_i = 1'b1;
      wb_dat_i = 16'h5555;
      ready_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (core_ready !== 1'b0) ready_seen++;
      end
      wb_ack_i = 1'b0;
      n_vec++;
      if (ready_seen != 0) begin
         n_bad++;
         $display("FAIL wb_late_ack: core_ready seen %0d cycles required 0", ready_seen);
      end
      do_access(1'b0, 16'h0009, 16'h0000, 3'b000, 0, 0, rd, er, lat);
      n_vec++;
      if (lat !== 1 || rd !== ref_mem[9]) begin
         n_bad++;
         $display("FAIL after_reset_local: lat=%0d rdata=%h required 1/%h", lat, rd, ref_mem[9]);
      end
   endtask

`ifdef NRISC_DMEM_WB_TIMEOUT_EN
   task automatic test_timeout();
      logic [15:0] rd; logic er; int lat;
      do_access(1'b0, 16'h8040, 16'h0000, 3'b000, -1, 0, rd, er, lat);
      n_vec++;
      if (lat !== 10 || er !== 1'b1 || rd !== 16'h0) begin
         n_bad++;
         $display("FAIL wb_timeout: lat=%0d err=%b rdata=%h required 10/1/0000", lat, er, rd);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_local_word();
      test_local_byte();
      test_byte_store();
      test_alias();
      test_random_local();
      test_wb_load();
      test_wb_store();
      test_wb_error();
      test_random_wb();
      test_wb_reset();
`ifdef NRISC_DMEM_WB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
